// File: rtl/decode_pipe.sv
// Decode/EX/WB pipeline slice: operand select with EX and WB forwarding,
// a stallable EX register, and one-cycle register-write / display strobes.
module decode_pipe #(
  parameter int          DATA_W    = 8,
  parameter int          REG_AW    = 2,
  parameter logic [7:0]  IMM_MASK  = 8'b0101_0100,
  parameter logic [2:0]  DISP_OPC  = 3'b000,
  parameter logic [2:0]  STORE_OPC = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] src_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] src_b_data,
  input  logic              ex_stall,
  input  logic [DATA_W-1:0] alu_out,
  output logic              ex_valid,
  output logic [2:0]        ex_opcode,
  output logic [DATA_W-1:0] alu_operand,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              disp_en,
  output logic [DATA_W-1:0] disp_data,
  output logic [15:0]       retired
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] imm;
  } ex_t;

  ex_t               ex_q;
  logic              accept;
  logic              advance;
  logic              ex_is_disp;
  logic              ex_is_store;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] operand;

  // No skid buffer: a new instruction only enters when EX is empty or leaving.
  assign in_ready    = !ex_valid || !ex_stall;
  assign accept      = in_valid && in_ready;
  assign advance     = ex_valid && !ex_stall;
  assign ex_opcode   = ex_q.opcode;
  assign ex_is_disp  = (ex_q.opcode == DISP_OPC);
  assign ex_is_store = (ex_q.opcode == STORE_OPC);
  assign ex_result   = ex_is_store ? ex_q.imm : alu_out;

  // EX result is younger than WB, so it wins when both target src_b.
  always_comb begin
    fwd_b = src_b_data;
    if (ex_valid && !ex_is_disp && (ex_q.dst == src_b))
      fwd_b = ex_result;
    else if (wr_en && (wr_addr == src_b))
      fwd_b = wr_data;
    operand = IMM_MASK[opcode] ? imm : fwd_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_q        <= '0;
      alu_operand <= '0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_q        <= '{opcode: opcode, dst: dst, imm: imm};
      alu_operand <= operand;
    end else if (advance) begin
      ex_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      disp_en   <= 1'b0;
      disp_data <= '0;
      retired   <= '0;
    end else begin
      wr_en   <= advance && !ex_is_disp;
      disp_en <= advance && ex_is_disp;
      if (advance) begin
        wr_addr <= ex_q.dst;
        wr_data <= ex_result;
        retired <= retired + 16'd1;
        if (ex_is_disp) disp_data <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus random traffic, checked
// against an architectural register-file model (program-order semantics).
module tb_decode_pipe;
  localparam int         DW        = 8;
  localparam int         AW        = 2;
  localparam logic [7:0] IMM_MASK  = 8'b0101_0100;
  localparam logic [2:0] DISP      = 3'b000;
  localparam logic [2:0] STORE     = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] dst, src_b;
  logic [DW-1:0] imm, src_b_data, alu_out;
  logic          ex_stall, ex_valid;
  logic [2:0]    ex_opcode;
  logic [DW-1:0] alu_operand, wr_data, disp_data;
  logic          wr_en, disp_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   retired;

  int checks = 0;
  int errors = 0;

  // Reference model: arch = values after every accepted instruction in
  // program order; rf = the bench's register file, written one cycle after
  // the expected write strobe.
  logic [DW-1:0] arch [4];
  logic [DW-1:0] rf   [4];
  logic          m_ex_v;
  logic [2:0]    m_ex_opc;
  logic [AW-1:0] m_ex_dst;
  logic [DW-1:0] m_ex_imm, m_ex_res, m_ex_opnd;
  logic          m_wr_en, m_disp_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data, m_disp_data;
  logic [15:0]   m_ret;

  decode_pipe #(.DATA_W(DW), .REG_AW(AW), .IMM_MASK(IMM_MASK),
                .DISP_OPC(DISP), .STORE_OPC(STORE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .dst(dst), .src_b(src_b), .imm(imm),
    .src_b_data(src_b_data), .ex_stall(ex_stall), .alu_out(alu_out),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .alu_operand(alu_operand),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .disp_en(disp_en),
    .disp_data(disp_data), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ex_v = 0; m_ex_opc = '0; m_ex_dst = '0; m_ex_imm = '0; m_ex_res = '0;
    m_ex_opnd = '0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    m_disp_en = 0; m_disp_data = '0; m_ret = '0;
    for (int i = 0; i < 4; i++) arch[i] = rf[i];
  endtask

  task automatic preload(input int r, input logic [DW-1:0] v);
    rf[r] = v; arch[r] = v;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cycle(input bit go, input logic [2:0] opc, input logic [AW-1:0] d,
                       input logic [AW-1:0] sb, input logic [DW-1:0] im,
                       input logic [DW-1:0] res, input bit stall);
    bit adv, acc, exp_rdy;
    in_valid = go; opcode = opc; dst = d; src_b = sb; imm = im; ex_stall = stall;
    src_b_data = rf[sb];
    alu_out = m_ex_v ? m_ex_res : 8'($urandom);
    @(negedge clk);
    exp_rdy = !m_ex_v || !stall;
    checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy); end
    checks++; if (ex_valid !== m_ex_v) begin errors++; $display("FAIL ex_valid: got %b want %b", ex_valid, m_ex_v); end
    checks++; if (ex_opcode !== m_ex_opc) begin errors++; $display("FAIL ex_opcode: got %h want %h", ex_opcode, m_ex_opc); end
    checks++; if (alu_operand !== m_ex_opnd) begin errors++; $display("FAIL alu_operand: got %h want %h", alu_operand, m_ex_opnd); end
    checks++; if (wr_en !== m_wr_en) begin errors++; $display("FAIL wr_en: got %b want %b", wr_en, m_wr_en); end
    checks++; if (wr_addr !== m_wr_addr) begin errors++; $display("FAIL wr_addr: got %h want %h", wr_addr, m_wr_addr); end
    checks++; if (wr_data !== m_wr_data) begin errors++; $display("FAIL wr_data: got %h want %h", wr_data, m_wr_data); end
    checks++; if (disp_en !== m_disp_en) begin errors++; $display("FAIL disp_en: got %b want %b", disp_en, m_disp_en); end
    checks++; if (disp_data !== m_disp_data) begin errors++; $display("FAIL disp_data: got %h want %h", disp_data, m_disp_data); end
    checks++; if (retired !== m_ret) begin errors++; $display("FAIL retired: got %h want %h", retired, m_ret); end
    adv = m_ex_v && !stall;
    acc = go && exp_rdy;
    if (m_wr_en) rf[m_wr_addr] = m_wr_data;
    m_wr_en   = adv && (m_ex_opc != DISP);
    m_disp_en = adv && (m_ex_opc == DISP);
    if (adv) begin
      m_wr_addr = m_ex_dst;
      m_wr_data = (m_ex_opc == STORE) ? m_ex_imm : m_ex_res;
      if (m_ex_opc == DISP) m_disp_data = m_ex_res;
      m_ret = m_ret + 16'd1;
    end
    if (acc) begin
      m_ex_opnd = IMM_MASK[opc] ? im : arch[sb];
      m_ex_opc = opc; m_ex_dst = d; m_ex_imm = im; m_ex_res = res; m_ex_v = 1;
      if (opc != DISP) arch[d] = (opc == STORE) ? im : res;
    end else if (adv) begin
      m_ex_v = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, '0, '0, '0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; ex_stall = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; opcode = 3'b001; dst = 1; src_b = 0; imm = 8'h12;
    src_b_data = 8'h34; ex_stall = 0; alu_out = 8'h56;
    @(posedge clk); #1;
    checks++; if ({ex_valid, wr_en, disp_en, retired, wr_addr, wr_data, disp_data, alu_operand, ex_opcode} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ev=%b we=%b de=%b ret=%h wa=%h wd=%h dd=%h op=%h eo=%h want all 0",
        ex_valid, wr_en, disp_en, retired, wr_addr, wr_data, disp_data, alu_operand, ex_opcode); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    model_reset();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b want 0", ex_valid); end
  endtask

  task automatic test_basic();
    preload(2, 8'h05);
    cycle(1, 3'b001, 2'd1, 2'd2, 8'h00, 8'h09, 0);
    checks++; if (alu_operand !== 8'h05) begin errors++; $display("FAIL basic_operand: got %h want 05", alu_operand); end
    idle(1);
    checks++; if ({wr_en, wr_addr, wr_data, retired} !== {1'b1, 2'd1, 8'h09, 16'd1}) begin
      errors++; $display("FAIL basic_wb: got we=%b wa=%h wd=%h ret=%h want 1/1/09/1", wr_en, wr_addr, wr_data, retired); end
    idle(1);
  endtask

  task automatic test_imm();
    idle(2); preload(1, 8'hAA);
    cycle(1, 3'b010, 2'd0, 2'd1, 8'h3C, 8'h55, 0);
    checks++; if (alu_operand !== 8'h3C) begin errors++; $display("FAIL imm_operand: got %h want 3c", alu_operand); end
    cycle(1, STORE, 2'd3, 2'd0, 8'h7E, 8'h99, 0);
    idle(1);
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 2'd3, 8'h7E}) begin
      errors++; $display("FAIL store_wb: got we=%b wa=%h wd=%h want 1/3/7e", wr_en, wr_addr, wr_data); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    idle(2); preload(2, 8'hEE);
    cycle(1, 3'b001, 2'd2, 2'd0, 8'h00, 8'h11, 0);
    cycle(1, 3'b011, 2'd1, 2'd2, 8'h00, 8'h22, 0);
    checks++; if (alu_operand !== 8'h11) begin errors++; $display("FAIL fwd_ex: got %h want 11", alu_operand); end
    cycle(1, 3'b001, 2'd3, 2'd2, 8'h00, 8'h33, 0);
    checks++; if (alu_operand !== 8'h11) begin errors++; $display("FAIL fwd_wb: got %h want 11", alu_operand); end
    idle(2);
  endtask

  task automatic test_stall();
    idle(2); preload(1, 8'h3D);
    cycle(1, 3'b001, 2'd0, 2'd1, 8'h00, 8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'b011, 2'd2, 2'd0, 8'h00, 8'h6B, 1);
      checks++; if ({in_ready, wr_en, alu_operand} !== {1'b0, 1'b0, 8'h3D}) begin
        errors++; $display("FAIL stall_hold: got rdy=%b we=%b op=%h want 0/0/3d", in_ready, wr_en, alu_operand); end
    end
    cycle(1, 3'b011, 2'd2, 2'd0, 8'h00, 8'h6B, 0);
    checks++; if ({wr_en, wr_data, ex_valid, ex_opcode} !== {1'b1, 8'h5A, 1'b1, 3'b011}) begin
      errors++; $display("FAIL stall_release: got we=%b wd=%h ev=%b eo=%h want 1/5a/1/3", wr_en, wr_data, ex_valid, ex_opcode); end
    idle(2);
  endtask

  task automatic test_disp();
    logic [15:0] r0;
    r0 = m_ret;
    cycle(1, DISP, 2'd1, 2'd0, 8'h00, 8'h42, 0);
    idle(1);
    checks++; if ({disp_en, disp_data, wr_en, retired} !== {1'b1, 8'h42, 1'b0, r0 + 16'd1}) begin
      errors++; $display("FAIL disp: got de=%b dd=%h we=%b ret=%h want 1/42/0/%h", disp_en, disp_data, wr_en, retired, r0 + 16'd1); end
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
    idle(2);
  endtask

  task automatic test_reset_stall();
    cycle(1, 3'b001, 2'd1, 2'd0, 8'h00, 8'h77, 0);
    cycle(0, 3'd0, '0, '0, '0, '0, 1);
    ex_stall = 1;
    #2 rst_n = 0;
    #1;
    checks++; if ({ex_valid, wr_en, disp_en, retired, wr_addr, wr_data, disp_data, alu_operand, ex_opcode} !== '0) begin
      errors++; $display("FAIL async_reset: got ev=%b we=%b de=%b ret=%h wa=%h wd=%h dd=%h op=%h eo=%h want all 0",
        ex_valid, wr_en, disp_en, retired, wr_addr, wr_data, disp_data, alu_operand, ex_opcode); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_rdy: got %b want 1", in_ready); end
    ex_stall = 0; in_valid = 1;
    @(posedge clk); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", ex_valid); end
    in_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    model_reset();
    idle(3);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++)
      cycle(1, 3'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 0);
    idle(1);
    checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL retired_max: got %h want ffff", retired); end
    cycle(1, 3'b001, 2'd0, 2'd1, 8'h00, 8'h01, 0);
    idle(1);
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL retired_wrap: got %h want 0000", retired); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin rf[i] = '0; arch[i] = '0; end
    model_reset();
    test_reset();
    test_basic();
    test_imm();
    test_back_to_back();
    test_stall();
    test_disp();
    test_random();
    test_reset_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 8: width of immediate, operand and write data.
REQ-002 Parameter REG_AW, default 2: register address width.
REQ-003 Parameter IMM_MASK, default 8'b0101_0100: bit k set means opcode k takes the immediate as ALU operand.
REQ-004 Parameter DISP_OPC, default 3'b000: display opcode, which performs no register write.
REQ-005 Parameter STORE_OPC, default 3'b111: store-immediate opcode, which writes imm.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  1  instruction offered.
REQ-009 in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-010 opcode  in  3  instruction opcode.
REQ-011 dst  in  REG_AW  destination register.
REQ-012 src_b  in  REG_AW  operand-B register address.
REQ-013 imm  in  DATA_W  immediate.
REQ-014 src_b_data  in  DATA_W  register-file read data for src_b.
REQ-015 ex_stall  in  1  ALU not done; hold the EX stage.
REQ-016 alu_out  in  DATA_W  combinational ALU result for the EX-stage operation.
REQ-017 ex_valid  out  1  EX stage holds an instruction.
REQ-018 ex_opcode  out  3  EX-stage opcode, to the ALU.
REQ-019 alu_operand  out  DATA_W  registered ALU operand B.
REQ-020 wr_en  out  1  register write strobe, one cycle.
REQ-021 wr_addr  out  REG_AW  write address.
REQ-022 wr_data  out  DATA_W  write data.
REQ-023 disp_en  out  1  display strobe, one cycle.
REQ-024 disp_data  out  DATA_W  display value.
REQ-025 retired  out  16  count of instructions leaving EX; wraps from 0xFFFF to 0.

Function
REQ-026 Pipeline: accept, then EX (1+ cycles), then WB register; wr_en is asserted 2 cycles after acceptance when ex_stall is 0.
REQ-027 in_ready = !ex_valid || !ex_stall (combinational); there is no skid buffer.
REQ-028 EX advances on a cycle where ex_valid && !ex_stall; on acceptance, the EX register loads opcode, dst, imm and the operand, and ex_valid is set to 1.
REQ-029 If EX advances and no new instruction is accepted, ex_valid clears to 0.
REQ-030 Operand: imm if IMM_MASK[opcode] is set, else the forwarded B value.
REQ-031 Forward priority 1: ex_valid && ex_opcode!=DISP_OPC && ex_dst==src_b selects the EX result, which is ex_imm if STORE_OPC, else alu_out.
REQ-032 Forward priority 2: wr_en && wr_addr==src_b selects wr_data.
REQ-033 Otherwise the operand is src_b_data.
REQ-034 On EX advance: wr_en <= (ex_opcode!=DISP_OPC); wr_addr <= ex_dst; wr_data <= STORE_OPC ? ex_imm : alu_out.
REQ-035 On EX advance with DISP_OPC: disp_en <= 1 and disp_data <= alu_out.
REQ-036 wr_en and disp_en are 0 in every cycle without an EX advance; wr_addr, wr_data and disp_data hold their values.
REQ-037 retired increments by 1 on each EX advance, regardless of opcode.
REQ-038 Stalled EX: alu_operand, ex_opcode and ex_valid are held constant while ex_stall=1.
REQ-039 Accept and advance in the same cycle are allowed, giving back-to-back throughput of 1 per cycle.

Reset
REQ-040 rst_n=0 asynchronously clears ex_valid, wr_en, disp_en, retired, wr_addr, wr_data, disp_data, alu_operand and ex_opcode to 0.
REQ-041 During reset in_ready=1, because ex_valid=0; offered instructions are not accepted until the first rising edge with rst_n=1.
REQ-042 Reset mid-stall discards the EX instruction, and no wr_en or disp_en is produced for it.

Verification
REQ-043 Reset then ADD opcode 001, dst=1, src_b=2, src_b_data=0x05, alu_out=0x09 -> alu_operand=0x05 at cycle 1; wr_en=1, wr_addr=1, wr_data=0x09 at cycle 2; retired=1.
REQ-044 Opcode 010, imm=0x3C, src_b_data=0xAA -> alu_operand=0x3C; opcode 111, imm=0x7E, dst=3 -> wr_data=0x7E, wr_addr=3.
REQ-045 Back-to-back: opcode 001 dst=2 (alu_out=0x11), then opcode 011 src_b=2 -> second alu_operand=0x11 via EX forward; a third instruction with src_b=2 -> WB forward 0x11.
REQ-046 ex_stall=1 for 3 cycles with ex_valid=1 -> in_ready=0, alu_operand stable, no wr_en; release -> single wr_en, next instruction accepted the same cycle.
REQ-047 Opcode 000 with alu_out=0x42 -> disp_en=1 and disp_data=0x42 for one cycle, wr_en=0, retired increments.
REQ-048 retired preloaded to 0xFFFF via 65535 instructions, one more retire -> retired=0x0000; rst_n low during a stall -> all outputs 0 immediately.
